cnt_seq_ctrl: RTL and testbench

Sequencer for a cascaded VCB4RE-style counter chain (N bits, built from 4-bit stages linked by CEO→CE). It owns the chain's clock-enable and synchronous clear. It paces counting through a programmable prescaler and stops or reloads when the chain reaches a programmed limit. It sits between the control/register logic (start/stop, settings) and the counter datapath, whose Q it monitors.

---
 rtl/cnt_seq_pkg.sv | 16 +
 rtl/cnt_seq_ctrl_if.sv | 33 +++
 rtl/cnt_seq_ctrl_ce_presc.sv | 33 +++
 rtl/cnt_seq_ctrl.sv | 116 +++++++++++
 tb/tb_cnt_seq_ctrl.sv | 217 +++++++++++++++++++++
 5 files changed

// File: rtl/cnt_seq_pkg.sv
// cnt_seq_pkg: shared definitions for the counter-chain sequencer.
//   - state encodings of the sequencer FSM (also exported as a debug port)
//   - default widths for the prescaler (PW) and the counter chain (N)
package cnt_seq_pkg;

    localparam int PW_DEF = 8;   // prescaler width, divide ratio = presc+1
    localparam int N_DEF  = 16;  // counter-chain width, multiple of 4

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CLR  = 2'd1,
        ST_RUN  = 2'd2,
        ST_HOLD = 2'd3
    } state_e;

endpackage

// File: rtl/cnt_seq_ctrl_if.sv
// cnt_seq_ctrl_if: bundle between the register/control side, the sequencer
// and the counter chain.
//   control -> seq : start, stop, mode, presc, limit
//   chain   -> seq : cnt_q
//   seq     -> out : cnt_ce, cnt_clr (to chain), busy, done, state, pc (debug)
// Modports: master = control/chain side, slave = sequencer.
interface cnt_seq_ctrl_if #(
    parameter int PW = cnt_seq_pkg::PW_DEF,
    parameter int N  = cnt_seq_pkg::N_DEF
);
    logic                  start;
    logic                  stop;
    logic                  mode;
    logic [PW-1:0]         presc;
    logic [N-1:0]          limit;
    logic [N-1:0]          cnt_q;
    logic                  cnt_ce;
    logic                  cnt_clr;
    logic                  busy;
    logic                  done;
    cnt_seq_pkg::state_e   state;
    logic [PW-1:0]         pc;

    modport master (
        output start, stop, mode, presc, limit, cnt_q,
        input  cnt_ce, cnt_clr, busy, done, state, pc
    );

    modport slave (
        input  start, stop, mode, presc, limit, cnt_q,
        output cnt_ce, cnt_clr, busy, done, state, pc
    );
endinterface

// File: rtl/cnt_seq_ctrl_ce_presc.sv
// ce_presc: PW-bit prescaler that paces the counter chain.
//   clk, clr_n : clock, asynchronous active-low reset
//   clear      : synchronous reset of pc to 0 (wins over run)
//   run        : advance pc this cycle; pc counts 0..presc and wraps
//   presc      : terminal prescaler value
//   pc         : current prescaler count
//   wrap       : pc == presc, i.e. this cycle is a count window
module ce_presc
    import cnt_seq_pkg::*;
#(
    parameter int PW = PW_DEF
) (
    input  logic          clk,
    input  logic          clr_n,
    input  logic          clear,
    input  logic          run,
    input  logic [PW-1:0] presc,
    output logic [PW-1:0] pc,
    output logic          wrap
);

    assign wrap = (pc == presc);

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n)
            pc <= '0;
        else if (clear)
            pc <= '0;
        else if (run)
            pc <= wrap ? '0 : pc + 1'b1;
    end

endmodule

// File: rtl/cnt_seq_ctrl.sv
// cnt_seq_ctrl: sequencer for a cascaded 4-bit-stage counter chain.
// Owns the chain's CE and synchronous clear, paces counting through a
// prescaler and stops (one-shot) or reloads (auto-reload) at a limit.
//   clk, clr_n : clock, asynchronous active-low reset
//   bus        : cnt_seq_ctrl_if.slave
//     start/stop  : run control, stop has priority
//     mode        : 0 one-shot, 1 auto-reload
//     presc/limit : settings, latched on every entry to CLR
//     cnt_q       : chain Q, monitored for the terminal compare
//     cnt_ce      : CE to the first chain stage
//     cnt_clr     : synchronous clear to all chain stages
//     busy, done  : status; done is a one-cycle pulse after terminal count
//     state, pc   : debug
module cnt_seq_ctrl
    import cnt_seq_pkg::*;
#(
    parameter int PW = PW_DEF,
    parameter int N  = N_DEF
) (
    input logic           clk,
    input logic           clr_n,
    cnt_seq_ctrl_if.slave bus
);

    state_e        state_q, state_d;
    logic          mode_s;
    logic [PW-1:0] presc_s;
    logic [N-1:0]  limit_s;
    logic          done_q, done_d;
    logic          load;
    logic          is_run;
    logic          wrap;
    logic          term;
    logic [PW-1:0] pc;

    assign is_run = (state_q == ST_RUN);

    // The chain is expected to sit exactly on limit_s at the terminal
    // window; >= keeps an out-of-range chain from running away.
    assign term = is_run && wrap && (bus.cnt_q >= limit_s);

    ce_presc #(.PW(PW)) u_presc (
        .clk   (clk),
        .clr_n (clr_n),
        .clear (state_q == ST_CLR),
        .run   (is_run),
        .presc (presc_s),
        .pc    (pc),
        .wrap  (wrap)
    );

    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.start && !bus.stop) begin
                    state_d = ST_CLR;
                    load    = 1'b1;
                end
            end
            ST_CLR: state_d = ST_RUN;
            ST_RUN: begin
                // stop outranks the terminal count: the sequence pauses
                // and the terminal window is revisited after resume.
                if (bus.stop) begin
                    state_d = ST_HOLD;
                end else if (term) begin
                    done_d = 1'b1;
                    if (mode_s) begin
                        state_d = ST_CLR;
                        load    = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_HOLD: begin
                if (bus.stop)
                    state_d = ST_IDLE;
                else if (bus.start)
                    state_d = ST_RUN;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state_q <= ST_IDLE;
            done_q  <= 1'b0;
            mode_s  <= 1'b0;
            presc_s <= '0;
            limit_s <= '0;
        end else begin
            state_q <= state_d;
            done_q  <= done_d;
            if (load) begin
                mode_s  <= bus.mode;
                presc_s <= bus.presc;
                limit_s <= bus.limit;
            end
        end
    end

    // CE is combinational so the chain increments on the same edge that
    // closes the count window.
    assign bus.cnt_ce  = is_run && wrap && !term;
    assign bus.cnt_clr = (state_q == ST_CLR);
    assign bus.busy    = (state_q != ST_IDLE);
    assign bus.done    = done_q;
    assign bus.state   = state_q;
    assign bus.pc      = pc;

endmodule

// File: tb/tb_cnt_seq_ctrl.sv
module tb_cnt_seq_ctrl;
    import cnt_seq_pkg::*;

    localparam int PW = PW_DEF;
    localparam int N  = N_DEF;
    localparam int NS = N / 4;

    logic clk   = 1'b0;
    logic clr_n = 1'b0;
    always #5 clk = ~clk;

    cnt_seq_ctrl_if #(.PW(PW), .N(N)) bus ();

    cnt_seq_ctrl #(.PW(PW), .N(N)) dut (
        .clk   (clk),
        .clr_n (clr_n),
        .bus   (bus)
    );

    // Counter chain: NS VCB4RE-style stages, CEO = CE & (Q == 4'hF).
    logic [N-1:0]  q;
    logic [NS-1:0] ce_ch;
    assign ce_ch[0]  = bus.cnt_ce;
    assign bus.cnt_q = q;

    for (genvar g = 0; g < NS; g++) begin : g_stage
        always @(posedge clk) begin
            if (bus.cnt_clr)
                q[4*g +: 4] <= 4'h0;
            else if (ce_ch[g])
                q[4*g +: 4] <= q[4*g +: 4] + 4'h1;
        end
        if (g < NS - 1) begin : g_carry
            assign ce_ch[g+1] = ce_ch[g] && (q[4*g +: 4] == 4'hF);
        end
    end

    int          nvec = 0;
    int          nerr = 0;
    int          cidx;
    logic [31:0] ce_h, clr_h, done_h, busy_h, hold_h;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic clr_hist();
        cidx   = 0;
        ce_h   = '0;
        clr_h  = '0;
        done_h = '0;
        busy_h = '0;
        hold_h = '0;
    endtask

    // Advance to cycle cidx (just after its opening edge) and log outputs.
    task automatic cyc();
        @(posedge clk);
        #1;
        if (cidx < 32) begin
            ce_h[cidx]   = bus.cnt_ce;
            clr_h[cidx]  = bus.cnt_clr;
            done_h[cidx] = bus.done;
            busy_h[cidx] = bus.busy;
            hold_h[cidx] = (bus.state == ST_HOLD);
        end
        cidx++;
    endtask

    task automatic cycs(input int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    // Start a sequence: start sampled at edge 0, returns in cycle 0.
    task automatic go(input logic m, input logic [PW-1:0] p, input logic [N-1:0] l);
        bus.mode  = m;
        bus.presc = p;
        bus.limit = l;
        bus.start = 1'b1;
        clr_hist();
        cyc();
        bus.start = 1'b0;
    endtask

    function automatic logic [31:0] outs4();
        return 32'({bus.cnt_ce, bus.cnt_clr, bus.busy, bus.done});
    endfunction

    initial begin
        bus.start = 1'b0;
        bus.stop  = 1'b0;
        bus.mode  = 1'b0;
        bus.presc = '0;
        bus.limit = '0;
        clr_hist();

        // reset state
        #12;
        chk("rst state", 32'(bus.state), 32'd0);
        chk("rst outs", outs4(), 32'd0);
        clr_n = 1'b1;

        // one-shot presc=1 limit=3; input changes mid-run must be ignored
        go(1'b0, 8'd1, 16'd3);
        bus.presc = 8'd5;
        bus.limit = 16'd7;
        bus.mode  = 1'b1;
        cycs(15);
        chk("os clr", clr_h, 32'h0000_0001);
        chk("os ce", ce_h, 32'h0000_0054);
        chk("os done", done_h, 32'h0000_0200);
        chk("os busy", busy_h, 32'h0000_01FF);
        chk("os q", 32'(q), 32'd3);
        chk("os state", 32'(bus.state), 32'd0);

        // auto-reload presc=0 limit=2, q sequence 0,1,2,(2),0,1,2...
        go(1'b1, 8'd0, 16'd2);
        begin : ar_run
            logic [31:0] q_h;
            q_h = '0;
            q_h[3:0] = q[3:0];
            for (int i = 1; i < 16; i++) begin
                cyc();
                if (i < 8) q_h[4*i +: 4] = q[3:0];
            end
            chk("ar q seq", q_h, 32'h2102_2103);
        end
        chk("ar clr", clr_h, 32'h0000_1111);
        chk("ar done", done_h, 32'h0000_1110);
        chk("ar ce", ce_h, 32'h0000_6666);
        // cycle 15 is a terminal window; stop must win over reload
        bus.stop = 1'b1;
        cyc();
        chk("ar stop>T state", 32'(bus.state), 32'(ST_HOLD));
        chk("ar stop>T done", 32'(bus.done), 32'd0);
        cyc();
        chk("ar abort state", 32'(bus.state), 32'(ST_IDLE));
        chk("ar abort outs", outs4(), 32'd0);
        chk("ar abort q", 32'(q), 32'd2);
        bus.stop = 1'b0;

        // pause/resume: stop at edge 4, 5 quiet cycles, start at edge 10
        go(1'b0, 8'd1, 16'd3);
        cycs(3);
        bus.stop = 1'b1;
        cyc();
        bus.stop = 1'b0;
        cycs(5);
        chk("pr frozen q", 32'(q), 32'd1);
        chk("pr frozen pc", 32'(bus.pc), 32'd1);
        bus.start = 1'b1;
        cyc();
        bus.start = 1'b0;
        cycs(9);
        chk("pr hold", hold_h, 32'h0000_03F0);
        chk("pr ce", ce_h, 32'h0000_1404);
        chk("pr done", done_h, 32'h0000_8000);
        chk("pr busy", busy_h, 32'h0000_7FFF);
        chk("pr q", 32'(q), 32'd3);

        // simultaneous start+stop in IDLE, RUN, HOLD
        bus.start = 1'b1;
        bus.stop  = 1'b1;
        cyc();
        chk("ss idle state", 32'(bus.state), 32'(ST_IDLE));
        chk("ss idle outs", outs4(), 32'd0);
        bus.stop = 1'b0;
        go(1'b0, 8'd3, 16'd5);
        cyc();
        bus.start = 1'b1;
        bus.stop  = 1'b1;
        cyc();
        chk("ss run state", 32'(bus.state), 32'(ST_HOLD));
        cyc();
        chk("ss hold state", 32'(bus.state), 32'(ST_IDLE));
        chk("ss hold outs", outs4(), 32'd0);
        bus.start = 1'b0;
        bus.stop  = 1'b0;

        // limit=0 presc=0: no CE, done two cycles after the start edge
        go(1'b0, 8'd0, 16'd0);
        cycs(5);
        chk("l0 ce", ce_h, 32'd0);
        chk("l0 done", done_h, 32'h0000_0004);
        chk("l0 busy", busy_h, 32'h0000_0003);
        chk("l0 q", 32'(q), 32'd0);

        // asynchronous reset mid-RUN, then a fresh sequence
        go(1'b1, 8'd2, 16'd5);
        cycs(4);
        chk("ar2 pre q", 32'(q), 32'd1);
        chk("ar2 pre busy", 32'(bus.busy), 32'd1);
        #3;
        clr_n = 1'b0;
        #1;
        chk("async outs", outs4(), 32'd0);
        chk("async state", 32'(bus.state), 32'(ST_IDLE));
        cyc();
        chk("async chain kept", 32'(q), 32'd1);
        clr_n = 1'b1;
        go(1'b0, 8'd0, 16'd1);
        cycs(5);
        chk("fresh clr", clr_h, 32'h0000_0001);
        chk("fresh ce", ce_h, 32'h0000_0002);
        chk("fresh done", done_h, 32'h0000_0008);
        chk("fresh busy", busy_h, 32'h0000_0007);
        chk("fresh q", 32'(q), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
